// File: rtl/clk_period_meter.sv
// Measures high time, low time and period of a slow asynchronous clock in system-clock cycles,
// and declares lock once consecutive half-periods match the expected value.
module clk_period_meter #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned EXP_HALF = 3,
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_N   = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_clk,
    input  logic             enable,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             locked,
    output logic             err
);

    localparam int unsigned MatchW  = $clog2(LOCK_N + 1);
    localparam int unsigned LoBound = (EXP_HALF > TOL) ? EXP_HALF - TOL : 0;
    localparam int unsigned HiBound = EXP_HALF + TOL;

    localparam logic [CNT_W-1:0]  CntMax     = '1;
    localparam logic [CNT_W-1:0]  TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [MatchW-1:0] LockVal    = MatchW'(LOCK_N);

    typedef enum logic [1:0] {StIdle, StAcq, StRun} state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync2_q, hist_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MatchW-1:0]   match_q, match_d;
    logic                have_high_q, have_high_d;
    logic [CNT_W-1:0]    high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]    low_cnt_q, low_cnt_d;
    logic [CNT_W:0]      period_q, period_d;
    logic                meas_valid_q, meas_valid_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;

    logic                edge_det;
    logic                fall;
    logic [CNT_W-1:0]    cnt_inc;
    logic [MatchW-1:0]   match_inc;
    logic [31:0]         cnt_ext;
    logic                in_win;
    logic [CNT_W:0]      sum;

    assign edge_det  = sync2_q ^ hist_q;
    assign fall      = edge_det & ~sync2_q;
    assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    assign match_inc = (match_q == LockVal) ? match_q : match_q + 1'b1;
    assign cnt_ext   = 32'(cnt_q);
    // A saturated count is never a valid half-period, whatever the window.
    assign in_win    = (cnt_ext >= LoBound) && (cnt_ext <= HiBound) && (cnt_q != CntMax);
    assign sum       = {1'b0, high_cnt_q} + {1'b0, cnt_q};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        match_d      = match_q;
        have_high_d  = have_high_q;
        high_cnt_d   = high_cnt_q;
        low_cnt_d    = low_cnt_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        err_d        = 1'b0;

        if (!enable) begin
            state_d     = StIdle;
            cnt_d       = '0;
            match_d     = '0;
            have_high_d = 1'b0;
            locked_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StAcq;
                    cnt_d   = '0;
                end
                StAcq, StRun: begin
                    if (edge_det) begin
                        cnt_d = CNT_W'(1);
                        if (state_q == StAcq) begin
                            // Preceding level is partial, so the first edge only starts timing.
                            state_d = StRun;
                        end else begin
                            if (fall) begin
                                high_cnt_d  = cnt_q;
                                have_high_d = 1'b1;
                            end else begin
                                low_cnt_d = cnt_q;
                                if (have_high_q) begin
                                    period_d     = sum;
                                    meas_valid_d = 1'b1;
                                end
                            end
                            if (in_win) begin
                                match_d  = match_inc;
                                locked_d = (match_inc == LockVal);
                            end else begin
                                match_d  = '0;
                                locked_d = 1'b0;
                                err_d    = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        // cnt keeps counting past TIMEOUT, so this fires once per drop-out.
                        if (cnt_q == TimeoutVal) begin
                            err_d       = 1'b1;
                            locked_d    = 1'b0;
                            match_d     = '0;
                            have_high_d = 1'b0;
                            state_d     = StAcq;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            hist_q       <= 1'b0;
            state_q      <= StIdle;
            cnt_q        <= '0;
            match_q      <= '0;
            have_high_q  <= 1'b0;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sync1_q      <= in_clk;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            match_q      <= match_d;
            have_high_q  <= have_high_d;
            high_cnt_q   <= high_cnt_d;
            low_cnt_q    <= low_cnt_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
        end
    end

    assign high_cnt   = high_cnt_q;
    assign low_cnt    = low_cnt_q;
    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign err        = err_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: stimulus pushes expected output events, a monitor
// pops and compares them whenever meas_valid or err is presented.
module tb_clk_period_meter;

    typedef struct {
        logic        v;
        logic        e;
        logic [15:0] h;
        logic [15:0] l;
        logic [16:0] p;
        logic        lk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in1, en1, in2, en2;
    logic [15:0] h1, l1, h2, l2;
    logic [16:0] p1, p2;
    logic mv1, lk1, er1, mv2, lk2, er2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t x;
    int   checks = 0;
    int   errors = 0;
    int   got;

    always #5 clk = ~clk;

    clk_period_meter dut1 (
        .clk(clk), .rst_n(rst_n), .in_clk(in1), .enable(en1),
        .high_cnt(h1), .low_cnt(l1), .period(p1),
        .meas_valid(mv1), .locked(lk1), .err(er1)
    );

    clk_period_meter #(
        .TOL(1), .TIMEOUT(8)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .in_clk(in2), .enable(en2),
        .high_cnt(h2), .low_cnt(l2), .period(p2),
        .meas_valid(mv2), .locked(lk2), .err(er2)
    );

    task automatic chk(input string nm, input longint gotv, input longint want);
        checks++;
        if (gotv != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, gotv, want);
        end
    endtask

    task automatic cmp(input string nm, input exp_t w, input logic v, input logic e,
                       input logic [15:0] h, input logic [15:0] l, input logic [16:0] p,
                       input logic lk);
        checks++;
        if (v !== w.v || e !== w.e || h !== w.h || l !== w.l || p !== w.p || lk !== w.lk) begin
            errors++;
            $display("FAIL %s event: got v=%0b err=%0b h=%0d l=%0d p=%0d lk=%0b, want v=%0b err=%0b h=%0d l=%0d p=%0d lk=%0b",
                     nm, v, e, h, l, p, lk, w.v, w.e, w.h, w.l, w.p, w.lk);
        end
    endtask

    // Drive a new level (ending the previous one), optionally push the expected event for the
    // capture this transition causes, then hold for n cycles.
    task automatic step(input int d, input logic v, input int n, input bit has, input logic ev,
                        input logic er, input int h, input int l, input int p, input logic lk);
        exp_t w;
        if (d == 1) in1 = v; else in2 = v;
        if (has) begin
            w.v = ev; w.e = er; w.h = 16'(h); w.l = 16'(l); w.p = 17'(p); w.lk = lk;
            if (d == 1) q1.push_back(w); else q2.push_back(w);
        end
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mv1 || er1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1 unexpected event: got v=%0b err=%0b h=%0d l=%0d p=%0d, want none",
                             mv1, er1, h1, l1, p1);
                end else begin
                    x = q1.pop_front();
                    cmp("dut1", x, mv1, er1, h1, l1, p1, lk1);
                end
            end
            if (mv2 || er2) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut2 unexpected event: got v=%0b err=%0b h=%0d l=%0d p=%0d, want none",
                             mv2, er2, h2, l2, p2);
                end else begin
                    x = q2.pop_front();
                    cmp("dut2", x, mv2, er2, h2, l2, p2, lk2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in1 = 1'b0; en1 = 1'b0; in2 = 1'b0; en2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset high_cnt", h1, 0);
        chk("reset low_cnt", l1, 0);
        chk("reset period", p1, 0);
        chk("reset meas_valid", mv1, 0);
        chk("reset locked", lk1, 0);
        chk("reset err", er1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        en1 = 1'b1;
        repeat (2) @(negedge clk);

        // Divide-by-6 lock, then a stretched high level.
        step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 1, 1, 0, 3, 3, 6, 0);
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 1, 1, 0, 3, 3, 6, 1);
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 1, 1, 0, 3, 3, 6, 1);
        step(1, 0, 3, 1, 0, 1, 5, 3, 6, 0);
        step(1, 1, 3, 1, 1, 0, 5, 3, 8, 0);
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 1, 1, 0, 3, 3, 6, 0);
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 1, 1, 0, 3, 3, 6, 1);
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);

        // Input stops high: one timeout err, 67 sampling edges after the transition.
        step(1, 1, 0, 1, 1, 0, 3, 3, 6, 1);
        x.v = 0; x.e = 1; x.h = 16'd3; x.l = 16'd3; x.p = 17'd6; x.lk = 0;
        q1.push_back(x);
        got = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (er1 && got < 0) got = k;
        end
        chk("dut1 timeout latency", got, 67);

        // Resume: first edge unmeasured, first rising capture has no high half yet.
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 1, 1, 0, 3, 3, 6, 0);
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 1, 1, 0, 3, 3, 6, 1);

        // Enable dropped mid-run.
        chk("locked before disable", lk1, 1);
        en1 = 1'b0;
        @(negedge clk);
        chk("disable locked", lk1, 0);
        chk("disable meas_valid", mv1, 0);
        chk("disable holds high_cnt", h1, 3);
        chk("disable holds low_cnt", l1, 3);
        chk("disable holds period", p1, 6);
        repeat (4) @(negedge clk);
        en1 = 1'b1;
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 1, 1, 0, 3, 3, 6, 0);
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-run.
        chk("locked before reset", lk1, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        en1 = 1'b0;
        #1;
        chk("async reset high_cnt", h1, 0);
        chk("async reset low_cnt", l1, 0);
        chk("async reset period", p1, 0);
        chk("async reset locked", lk1, 0);
        chk("async reset meas_valid", mv1, 0);
        chk("async reset err", er1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // TOL=1, TIMEOUT=8: tolerance lock, out-of-window half, coincident edge at TIMEOUT.
        en2 = 1'b1;
        step(2, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        step(2, 0, 4, 0, 0, 0, 0, 0, 0, 0);
        step(2, 1, 3, 1, 1, 0, 2, 4, 6, 0);
        step(2, 0, 4, 0, 0, 0, 0, 0, 0, 0);
        step(2, 1, 5, 1, 1, 0, 3, 4, 7, 1);
        step(2, 0, 3, 1, 0, 1, 5, 4, 7, 0);
        step(2, 1, 8, 1, 1, 0, 5, 3, 8, 0);
        step(2, 0, 3, 1, 0, 1, 8, 3, 8, 0);
        step(2, 1, 0, 1, 1, 0, 8, 3, 11, 0);
        x.v = 0; x.e = 1; x.h = 16'd8; x.l = 16'd3; x.p = 17'd11; x.lk = 0;
        q2.push_back(x);
        got = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (er2 && got < 0) got = k;
        end
        chk("dut2 timeout latency", got, 11);
        en2 = 1'b0;

        repeat (5) @(negedge clk);
        chk("dut1 expected events left", q1.size(), 0);
        chk("dut2 expected events left", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
